// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
//   Shared definitions for the Tetris input path: button bit positions,
//   the per-button repeat channel state encoding and default DAS timing.
//   Imported by button_repeat_channel and button_repeat_gen.
// -----------------------------------------------------------------------------
package tetris_pkg;

  // Bit positions inside the 4-bit button vectors.
  localparam int BTN_LEFT   = 0;
  localparam int BTN_RIGHT  = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_ROTATE = 3;
  localparam int NUM_BTN    = 4;

  // Default timing at 50 MHz: ~267 ms to first repeat, ~50 ms between repeats.
  localparam int             DEFAULT_DELAY_CYCLES  = 13333333;
  localparam int             DEFAULT_REPEAT_CYCLES = 2500000;
  localparam int             DEFAULT_CNT_W         = 24;
  localparam logic [3:0]     DEFAULT_REPEAT_MASK   = 4'b0111;

  // Per-button channel state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HELD   = 2'd3
  } chan_state_t;

endpackage : tetris_pkg

// File: rtl/button_repeat_channel.sv
// -----------------------------------------------------------------------------
// button_repeat_channel
//   One button's delayed-auto-repeat FSM, its interval counter and the
//   pending-request bit handed to the grid controller.
//
//   Handshake: o_req is a level that rises on an event and stays high until
//   a cycle in which i_ack is high and no new event occurs. An event that
//   finds o_req already high without a same-cycle i_ack is lost and sets the
//   sticky o_drop. i_ack while o_req is low has no effect.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   i_button     in   held level of this button (already clk-synchronous)
//   i_ack        in   consume strobe from the grid controller
//   i_repeat_en  in   1: DELAY/REPEAT auto-repeat, 0: one event per press
//   o_req        out  pending move request
//   o_drop       out  sticky: an event was lost on this channel
//   o_state      out  current FSM state (observation only)
// -----------------------------------------------------------------------------
module button_repeat_channel
  import tetris_pkg::*;
#(
  parameter int DELAY_CYCLES  = DEFAULT_DELAY_CYCLES,
  parameter int REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
  parameter int CNT_W         = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_button,
  input  logic        i_ack,
  input  logic        i_repeat_en,
  output logic        o_req,
  output logic        o_drop,
  output chan_state_t o_state
);

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  chan_state_t      r_state;
  chan_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_event;
  logic             r_req;
  logic             r_drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Release is tested before the terminal count, so a release landing on the
  // terminal cycle produces no event.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_event     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_button) begin
          w_event     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = i_repeat_en ? ST_DELAY : ST_HELD;
        end
      end
      ST_DELAY: begin
        if (!i_button) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DELAY_LAST) begin
          w_event     = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REPEAT;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (!i_button) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == REPEAT_LAST) begin
          w_event     = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!i_button) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // An event wins over a same-cycle ack so a freshly re-armed request is
  // never swallowed by the ack of the previous one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_event) begin
        r_req <= 1'b1;
      end else if (i_ack) begin
        r_req <= 1'b0;
      end
      if (w_event && r_req && !i_ack) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign o_req   = r_req;
  assign o_drop  = r_drop;
  assign o_state = r_state;

endmodule : button_repeat_channel

// File: rtl/button_repeat_gen.sv
// -----------------------------------------------------------------------------
// button_repeat_gen
//   Turns the 4-bit held-button vector from the NES controller into one-shot
//   move requests with delayed auto-repeat, held until the grid controller
//   acknowledges them. One button_repeat_channel per button.
//
//   Optional build macro BUTTON_LR_LOCKOUT_EN: while left and right are both
//   held, both channels see their button as released; whichever remains held
//   afterwards starts as a fresh press. Without the macro left and right are
//   independent.
//
// Ports
//   clk          in   50 MHz system clock
//   reset        in   asynchronous, active-high reset
//   button_data  in   [3:0] held levels (0 left, 1 right, 2 down, 3 rotate)
//   move_ack     in   [3:0] per-button consume strobe
//   move_req     out  [3:0] per-button pending request
//   drop_flag    out  sticky lost-event indicator
// -----------------------------------------------------------------------------
module button_repeat_gen
  import tetris_pkg::*;
#(
  parameter int         DELAY_CYCLES  = DEFAULT_DELAY_CYCLES,
  parameter int         REPEAT_CYCLES = DEFAULT_REPEAT_CYCLES,
  parameter int         CNT_W         = DEFAULT_CNT_W,
  parameter logic [3:0] REPEAT_MASK   = DEFAULT_REPEAT_MASK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] button_data,
  input  logic [3:0] move_ack,
  output logic [3:0] move_req,
  output logic       drop_flag
);

  logic [NUM_BTN-1:0] w_btn;
  logic [NUM_BTN-1:0] w_drop;
  chan_state_t        w_chan_state [NUM_BTN];

`ifdef BUTTON_LR_LOCKOUT_EN
  logic w_lr_both;
  assign w_lr_both = button_data[BTN_LEFT] & button_data[BTN_RIGHT];

  always_comb begin
    w_btn = button_data;
    if (w_lr_both) begin
      w_btn[BTN_LEFT]  = 1'b0;
      w_btn[BTN_RIGHT] = 1'b0;
    end
  end
`else
  assign w_btn = button_data;
`endif

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    button_repeat_channel #(
      .DELAY_CYCLES  (DELAY_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .i_button    (w_btn[g]),
      .i_ack       (move_ack[g]),
      .i_repeat_en (REPEAT_MASK[g]),
      .o_req       (move_req[g]),
      .o_drop      (w_drop[g]),
      .o_state     (w_chan_state[g])
    );
  end

  assign drop_flag = |w_drop;

endmodule : button_repeat_gen

// File: tb/tb_button_repeat_gen.sv
// -----------------------------------------------------------------------------
// tb_button_repeat_gen
//   Directed bench for button_repeat_gen with DELAY_CYCLES = 8 and
//   REPEAT_CYCLES = 4. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at that same point, so every sample reflects the
//   edge just taken. "k" below counts edges since the press (k = 1 is the
//   first edge that sees the button high).
// -----------------------------------------------------------------------------
module tb_button_repeat_gen;

  localparam int CLK_HALF = 5;

  logic       clk;
  logic       reset;
  logic [3:0] button_data;
  logic [3:0] move_ack;
  logic [3:0] move_req;
  logic       drop_flag;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] exp_q[$];

  button_repeat_gen #(
    .DELAY_CYCLES  (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (4),
    .REPEAT_MASK   (4'b0111)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button_data (button_data),
    .move_ack    (move_ack),
    .move_req    (move_req),
    .drop_flag   (drop_flag)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #CLK_HALF clk = ~clk;

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag, input logic [3:0] obs, input logic [3:0] mask);
    logic [3:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(obs & mask), 32'(e & mask));
  endtask

  int ev_cnt;

  initial begin
    // ---------------- reset ----------------
    reset       = 1'b1;
    button_data = 4'b0000;
    move_ack    = 4'b0000;
    tick();
    tick();
    check("reset_req", 32'(move_req), 32'h0);
    check("reset_drop", 32'(drop_flag), 32'h0);
    reset = 1'b0;
    tick();
    check("idle_req", 32'(move_req), 32'h0);

    // ---------------- 1: tap left 3 cycles, ack next cycle ----------------
    button_data = 4'b0001;
    tick();                                   // k=1
    check("tap_req_k1", 32'(move_req), 32'h1);
    move_ack = 4'b0001;
    tick();                                   // k=2
    check("tap_req_k2", 32'(move_req), 32'h0);
    move_ack = 4'b0000;
    tick();                                   // k=3
    check("tap_req_k3", 32'(move_req), 32'h0);
    button_data = 4'b0000;
    tick();
    check("tap_req_rel", 32'(move_req), 32'h0);
    check("tap_drop", 32'(drop_flag), 32'h0);

    // ---------------- 2: hold down 20 cycles, ack immediately ----------------
    for (int k = 1; k <= 20; k++) begin
      exp_q.push_back((k == 1 || k == 9 || k == 13 || k == 17) ? 4'b0100 : 4'b0000);
    end
    ev_cnt = 0;
    button_data = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_pop($sformatf("down_req_k%0d", k), move_req, 4'b0100);
      if (move_req[2]) ev_cnt++;
      move_ack = {1'b0, move_req[2], 2'b00};
    end
    check("down_events", 32'(ev_cnt), 32'd4);
    button_data = 4'b0000;
    tick();
    move_ack = 4'b0000;
    check("down_drop", 32'(drop_flag), 32'h0);

    // ---------------- 3: hold rotate 20 cycles, no ack ----------------
    button_data = 4'b1000;
    tick();
    check("rot_req_k1", 32'(move_req), 32'h8);
    repeat (19) tick();
    check("rot_req_k20", 32'(move_req), 32'h8);
    check("rot_drop", 32'(drop_flag), 32'h0);
    button_data = 4'b0000;
    tick();
    check("rot_req_hold_after_rel", 32'(move_req), 32'h8);
    move_ack = 4'b1000;
    tick();
    move_ack = 4'b0000;
    check("rot_req_acked", 32'(move_req), 32'h0);
    // ack with nothing pending is ignored
    move_ack = 4'b1111;
    tick();
    move_ack = 4'b0000;
    check("stray_ack", 32'(move_req), 32'h0);

    // ---------------- 4: hold right 20 cycles, no ack ----------------
    button_data = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("right_req_k%0d", k), 32'(move_req), 32'h2);
      check($sformatf("right_drop_k%0d", k), 32'(drop_flag), (k >= 9) ? 32'h1 : 32'h0);
    end
    button_data = 4'b0000;
    move_ack    = 4'b0010;
    tick();
    move_ack    = 4'b0000;
    tick();
    check("right_req_cleared", 32'(move_req), 32'h0);
    check("drop_sticky", 32'(drop_flag), 32'h1);

    // ---------------- 5: reset mid-DELAY with left held ----------------
    button_data = 4'b0001;
    tick();
    check("rst5_req_k1", 32'(move_req), 32'h1);
    repeat (3) tick();
    reset = 1'b1;
    #2;                                       // no clock edge yet
    check("rst5_async_req", 32'(move_req), 32'h0);
    check("rst5_async_drop", 32'(drop_flag), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      exp_q.push_back((k == 1 || k == 9) ? 4'b0001 : 4'b0000);
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      check_pop($sformatf("rst5_req_k%0d", k), move_req, 4'b1111);
      move_ack = (k == 1) ? 4'b0001 : 4'b0000;
    end
    check("rst5_drop", 32'(drop_flag), 32'h0);
    button_data = 4'b0000;
    move_ack    = 4'b0001;
    tick();
    move_ack    = 4'b0000;
    tick();
    check("pre6_req", 32'(move_req), 32'h0);

    // ---------------- 6: left + right together, ack held high ----------------
    for (int k = 1; k <= 10; k++) begin
`ifdef BUTTON_LR_LOCKOUT_EN
      exp_q.push_back(4'b0000);
`else
      exp_q.push_back((k == 1 || k == 9) ? 4'b0011 : 4'b0000);
`endif
    end
    button_data = 4'b0011;
    move_ack    = 4'b0011;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_pop($sformatf("lr_req_k%0d", k), move_req, 4'b0011);
    end
    check("lr_drop", 32'(drop_flag), 32'h0);
    button_data = 4'b0000;
    tick();
    move_ack = 4'b0000;
    tick();
    check("final_req", 32'(move_req), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_button_repeat_gen
